// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the CPU M-stage port, with programmable wait states.
// Optional address checking (misaligned / out-of-range -> err) is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder #(
    parameter int unsigned AW      = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            bad_q;
    logic            bad_in;
    logic            commit;

    logic [31:0]     mem [0:(1<<AW)-1];

`ifdef DMEM_ADDR_CHECK_EN
    assign bad_in = (addr[1:0] != '0) || (addr[31:AW+2] != '0);
`else
    // Without checking, the byte-offset and high address bits are simply ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign bad_in = 1'b0;
`endif

    // An access only commits if the CPU is still requesting; a dropped req aborts it.
    assign commit = (state == BUSY) && req && (cnt == '0);
    assign stall  = req && (state != DONE);

    always_ff @(posedge clk) begin
        if (commit && we_q && !bad_q)
            mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            rdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        idx_q   <= addr[AW+1:2];
                        wdata_q <= wdata;
                        bad_q   <= bad_in;
                        cnt     <= 4'(LATENCY);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!we_q)
                            rdata <= bad_q ? 32'hDEADBEEF : mem[idx_q];
                        done  <= 1'b1;
                        err   <= bad_q;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=2, one with LATENCY=0.
// Honours DMEM_ADDR_CHECK_EN so the same bench covers both builds.
module tb_dmem_responder;

    localparam int unsigned AW = 10;
`ifdef DMEM_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic        stall_v [2];
    logic        done_v  [2];
    logic        err_v   [2];

    dmem_responder #(.AW(AW), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .stall(stall_v[0]), .done(done_v[0]), .err(err_v[0])
    );

    dmem_responder #(.AW(AW), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .stall(stall_v[1]), .done(done_v[1]), .err(err_v[1])
    );

    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    logic [31:0] model [2][int];
    logic [31:0] sb [$];
    logic [31:0] exp_rdata [2];
    int unsigned lat_of [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return ADDR_CHECK && ((a[1:0] != 2'b00) || (a[31:AW+2] != '0));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input string tag);
        int unsigned cyc;
        int unsigned stall_cyc;
        bit bad;
        bad = bad_addr(a);
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
        if (!w) begin
            sb.push_back(bad ? 32'hDEADBEEF : model[d][widx(a)]);
        end else if (!bad) begin
            model[d][widx(a)] = wd;
        end
        #1 check({tag, ".stall_req"}, stall_v[d], 1);
        @(posedge clk); #1;
        cyc = 0; stall_cyc = 0;
        while (done_v[d] !== 1'b1 && cyc < 40) begin
            if (stall_v[d] === 1'b1) stall_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".done_lat"}, cyc, lat_of[d] + 1);
        check({tag, ".stall_cyc"}, stall_cyc, lat_of[d] + 1);
        check({tag, ".stall_done"}, stall_v[d], 0);
        check({tag, ".err"}, err_v[d], bad);
        if (!w) begin
            exp_rdata[d] = sb.pop_front();
            check({tag, ".rdata"}, rdata_v[d], exp_rdata[d]);
        end else begin
            check({tag, ".rdata_hold"}, rdata_v[d], exp_rdata[d]);
        end
        @(negedge clk);
        req_v[d] = 1'b0;
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, done_v[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        lat_of[0] = 2; lat_of[1] = 0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; exp_rdata[i] = '0;
        end
        #23;
        for (int i = 0; i < 2; i++) begin
            check("rst.rdata", rdata_v[i], 0);
            check("rst.done", done_v[i], 0);
            check("rst.stall", stall_v[i], 0);
            check("rst.err", err_v[i], 0);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        access(0, 1'b1, 32'h10, 32'hCAFEBABE, "st10");
        access(0, 1'b0, 32'h10, 32'h0, "ld10");
        access(1, 1'b1, 32'h4, 32'h600DF00D, "l0_st4");
        access(1, 1'b0, 32'h4, 32'h0, "l0_ld4");

        // Abort: drop req after one BUSY cycle of a store.
        access(0, 1'b1, 32'h20, 32'h12345678, "st20");
        begin
            bit saw_done;
            saw_done = 1'b0;
            @(negedge clk);
            req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h11111111;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            req_v[0] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (done_v[0] === 1'b1) saw_done = 1'b1;
            end
            check("abort.no_done", saw_done, 0);
            check("abort.rdata", rdata_v[0], exp_rdata[0]);
        end
        access(0, 1'b0, 32'h20, 32'h0, "ld20");

        // Address wrap / checking.
        access(0, 1'b1, 32'h0, 32'h00C0FFEE, "st0");
        access(0, 1'b1, 32'h1000, 32'h5A5A5A5A, "st1000");
        access(0, 1'b0, 32'h0, 32'h0, "ld0");
        access(0, 1'b0, 32'h3, 32'h0, "ld3");

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] v;
            a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            v = $urandom;
            access(i % 2, 1'b1, a, v, "rnd_st");
            access(i % 2, 1'b0, a, 32'h0, "rnd_ld");
        end

        // Reset in the middle of a store must not commit it.
        access(0, 1'b1, 32'h40, 32'h0F0F0F0F, "st40");
        access(0, 1'b0, 32'h10, 32'h0, "ld10b");
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h40; wdata_v[0] = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        rst = 1'b0;
        #1;
        check("rstmid.done", done_v[0], 0);
        check("rstmid.rdata", rdata_v[0], 0);
        check("rstmid.stall", stall_v[0], 0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        #20;
        @(negedge clk); rst = 1'b1;
        access(0, 1'b0, 32'h40, 32'h0, "ld40");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's M-stage data port: serves the CPU's load/store requests (we, addr, wdata) and returns read data.
- Holds a word-addressed storage array and inserts a programmable number of wait states.
- Drives a stall back to the pipeline while an access is outstanding, so the core can run against slow memory models.
- Sits beside the CPU top: the CPU's memwriteM / aluoutM / writedataM feed we / addr / wdata; rdata feeds readdataM.

Parameters:
- AW, 10, word-address width; storage depth = 2**AW 32-bit words.
- LATENCY, 2, wait states inserted before the access commits (legal 0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request; held high by the CPU until done.
- we  in  1  1 = store, 0 = load; sampled at acceptance.
- addr  in  32  byte address; word index = addr[AW+1:2].
- wdata  in  32  store data; sampled at acceptance.
- rdata  out  32  registered load data.
- stall  out  1  combinational; = req & (state != DONE).
- done  out  1  one-cycle completion pulse.
- err  out  1  access error flag (optional feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0, rdata=0, done=0, err=0, latched we/addr/wdata cleared.
  - Storage array is not reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - At an edge with req=1, latch we/addr/wdata and set cnt=LATENCY.
  - Go to BUSY; with LATENCY=0, go straight to the commit edge.
- BUSY:
  - Each edge with cnt!=0 decrements cnt.
  - The edge where cnt==0 commits the access:
    - store: mem[idx] <= wdata;
    - load: rdata <= mem[idx].
  - done <= 1, state -> DONE.
- DONE:
  - done high for exactly one cycle; stall low, so the CPU advances.
  - Next edge: state -> IDLE, done <= 0.
- Latency:
  - Acceptance edge E0; commit at edge E0+LATENCY+1; done visible in the following cycle.
  - stall high for LATENCY+1 cycles.
  - A new request may be accepted at the edge after leaving DONE.
- req dropped while in BUSY: abort. Return to IDLE next edge; no write, rdata unchanged, no done pulse.
- rdata holds the last completed load value; stores and aborted accesses do not change it.
- Address wrap: index is addr[AW+1:2], so higher address bits are ignored (modulo depth). addr[1:0] is ignored.
- Same-word store then load: the load returns the newly stored data (the store commits before the load is accepted).
- Reset asserted mid-access: the access is lost; an in-flight store is not committed.

Optional Feature:
- Macro: DMEM_ADDR_CHECK_EN.
- With the macro defined, at the commit edge:
  - If addr[1:0]!=0 or addr[31:AW+2]!=0: err <= 1 together with done, and the store is suppressed.
  - A load in this case sets rdata <= 32'hDEADBEEF.
  - err clears with done.
- Without the macro: err is constant 0, and the wrap/ignore rules above apply.

Test Plan:
- Reset, then store with LATENCY=2: req=1, we=1, addr=0x10, wdata=0xCAFEBABE at E0 -> stall high 3 cycles, done pulses after edge E0+3; a later load of addr 0x10 returns rdata=0xCAFEBABE.
- LATENCY=0: load of addr 0x4 -> done in the cycle after edge E0+1; stall high for exactly 1 cycle.
- Abort: req dropped after 1 BUSY cycle of a store 0x11111111 to 0x20 -> no done; a subsequent load of 0x20 returns the prior contents.
- Wrap (macro off, AW=10): store 0x5A5A5A5A to 0x1000 -> a load of 0x0 returns 0x5A5A5A5A; err stays 0.
- Macro on: load from 0x3 -> err=1 and done=1 in the same cycle, rdata=0xDEADBEEF; a store to 0x1000 leaves word 0 unchanged.
- Async reset asserted during BUSY of a store -> done, rdata, and stall (with req=0) go to 0 immediately; the target word is unmodified.
